// File: rtl/tetris_pixel_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pixel_renderer
// Description : Pixel source between the video timing generator and the TMDS
//               encoders. Tracks the beam position from vde_in/cd_in, looks up
//               the Tetris playfield cell under the beam and emits 24-bit RGB
//               with vde/cd delayed to stay aligned (2-cycle latency).
//               Holds a double-buffered 10x20 board of 3-bit colour codes; the
//               front buffer is refreshed from the back buffer only on a vsync
//               rising edge, so a frame never shows a half-updated board.
// Ports       : pixclk, rst_n          - pixel clock, async active-low reset
//               vde_in, cd_in[1:0]     - timing input, cd_in = {vsync, hsync}
//               wr_en/wr_col/wr_row/wr_color - back-buffer cell write
//               swap_req / swap_ack    - publish request / copy-done pulse
//               vde_out, cd_out        - vde_in / cd_in delayed by 2
//               r_out, g_out, b_out    - pixel colour
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_pixel_renderer #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int CELL_LOG2 = 4,
    parameter int ORIGIN_X  = 240,
    parameter int ORIGIN_Y  = 80,
    parameter int BORDER    = 4
) (
    input  logic       pixclk,
    input  logic       rst_n,
    input  logic       vde_in,
    input  logic [1:0] cd_in,
    input  logic       wr_en,
    input  logic [3:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [2:0] wr_color,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       vde_out,
    output logic [1:0] cd_out,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out
);

    localparam int c_cols    = 10;
    localparam int c_rows    = 20;
    localparam int c_bits    = c_cols * c_rows * 3;
    localparam int c_board_w = c_cols << CELL_LOG2;
    localparam int c_board_h = c_rows << CELL_LOG2;

    localparam logic [11:0] c_x_max = 12'(H_ACTIVE - 1);
    localparam logic [11:0] c_y_max = 12'(V_ACTIVE - 1);
    localparam logic [11:0] c_bx0   = 12'(ORIGIN_X);
    localparam logic [11:0] c_bx1   = 12'(ORIGIN_X + c_board_w);
    localparam logic [11:0] c_by0   = 12'(ORIGIN_Y);
    localparam logic [11:0] c_by1   = 12'(ORIGIN_Y + c_board_h);
    localparam logic [11:0] c_rx0   = 12'(ORIGIN_X - BORDER);
    localparam logic [11:0] c_rx1   = 12'(ORIGIN_X + c_board_w + BORDER);
    localparam logic [11:0] c_ry0   = 12'(ORIGIN_Y - BORDER);
    localparam logic [11:0] c_ry1   = 12'(ORIGIN_Y + c_board_h + BORDER);

    localparam logic [1:0] c_cls_bg     = 2'd0;
    localparam logic [1:0] c_cls_border = 2'd1;
    localparam logic [1:0] c_cls_grid   = 2'd2;
    localparam logic [1:0] c_cls_cell   = 2'd3;

    // Boards are flat packed vectors: cell (row, col) lives at bits
    // [(row*10+col)*3 +: 3], which lets the swap copy as one assignment.
    logic [c_bits-1:0] r_front;
    logic [c_bits-1:0] r_back;

    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_vde_prev;
    logic        r_vs_prev;
    logic        r_swap_pending;
    logic        r_swap_ack;

    logic       r_vde_d1, r_vde_d2;
    logic [1:0] r_cd_d1, r_cd_d2;
    logic [1:0] r_s1_cls;
    logic [2:0] r_s1_code;
    logic [23:0] r_rgb;

    logic w_vs_rise;
    logic w_vde_fall;
    logic w_copy;
    logic w_wr_ok;
    logic [7:0] w_wr_idx;
    logic [9:0] w_wr_bit;

    assign w_vs_rise  = cd_in[1] & ~r_vs_prev;
    assign w_vde_fall = r_vde_prev & ~vde_in;
    assign w_copy     = w_vs_rise & r_swap_pending;
    assign w_wr_ok    = wr_en && (wr_col < 4'd10) && (wr_row < 5'd20);
    assign w_wr_idx   = ({3'b0, wr_row} * 8'd10) + {4'b0, wr_col};
    assign w_wr_bit   = {1'b0, w_wr_idx, 1'b0} + {2'b0, w_wr_idx};

    // ------------------------------------------------------------------
    // Beam position
    // ------------------------------------------------------------------
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_vde_prev <= 1'b0;
            r_vs_prev  <= 1'b0;
        end else begin
            r_vde_prev <= vde_in;
            r_vs_prev  <= cd_in[1];
            if (vde_in) begin
                if (r_x != c_x_max) r_x <= r_x + 12'd1;
            end else begin
                r_x <= '0;
            end
            if (w_vs_rise) begin
                r_y <= '0;
            end else if (w_vde_fall && (r_y != c_y_max)) begin
                r_y <= r_y + 12'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Board buffers and swap handshake. The copy samples r_back before this
    // edge, so a write in the copy cycle lands in back only. swap_req seen
    // in the copy cycle is folded into the swap in progress.
    // ------------------------------------------------------------------
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            r_front        <= '0;
            r_back         <= '0;
            r_swap_pending <= 1'b0;
            r_swap_ack     <= 1'b0;
        end else begin
            r_swap_ack <= w_copy;
            if (w_copy) begin
                r_front        <= r_back;
                r_swap_pending <= 1'b0;
            end else if (swap_req) begin
                r_swap_pending <= 1'b1;
            end
            if (w_wr_ok) r_back[w_wr_bit +: 3] <= wr_color;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: classify the pixel under the beam
    // ------------------------------------------------------------------
    logic [11:0] w_dx, w_dy;
    logic [3:0]  w_col;
    logic [4:0]  w_row;
    logic        w_in_board, w_in_ring, w_on_grid;
    logic [7:0]  w_rd_idx;
    logic [9:0]  w_rd_bit;
    logic [1:0]  w_cls;
    logic [2:0]  w_code;

    always_comb begin
        // Unsigned offsets; only meaningful when w_in_board is true.
        w_dx       = r_x - c_bx0;
        w_dy       = r_y - c_by0;
        w_col      = 4'(w_dx >> CELL_LOG2);
        w_row      = 5'(w_dy >> CELL_LOG2);
        w_in_board = (r_x >= c_bx0) && (r_x < c_bx1) && (r_y >= c_by0) && (r_y < c_by1);
        w_in_ring  = (r_x >= c_rx0) && (r_x < c_rx1) && (r_y >= c_ry0) && (r_y < c_ry1);
        w_on_grid  = (&w_dx[CELL_LOG2-1:0]) || (&w_dy[CELL_LOG2-1:0]);
        w_rd_idx   = '0;
        w_rd_bit   = '0;
        w_code     = '0;
        w_cls      = c_cls_bg;
        if (w_in_board) begin
            w_rd_idx = ({3'b0, w_row} * 8'd10) + {4'b0, w_col};
            w_rd_bit = {1'b0, w_rd_idx, 1'b0} + {2'b0, w_rd_idx};
            w_code   = r_front[w_rd_bit +: 3];
            w_cls    = w_on_grid ? c_cls_grid : c_cls_cell;
        end else if (w_in_ring) begin
            w_cls = c_cls_border;
        end
    end

    function automatic logic [23:0] f_palette(input logic [2:0] code);
        logic [23:0] rgb;
        case (code)
            3'd1:    rgb = 24'h00FFFF;
            3'd2:    rgb = 24'hFFFF00;
            3'd3:    rgb = 24'h800080;
            3'd4:    rgb = 24'h00FF00;
            3'd5:    rgb = 24'hFF0000;
            3'd6:    rgb = 24'h0000FF;
            3'd7:    rgb = 24'hFF8000;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1 / stage 2 registers and the matching vde/cd delay line
    // ------------------------------------------------------------------
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vde_d1  <= 1'b0;
            r_vde_d2  <= 1'b0;
            r_cd_d1   <= '0;
            r_cd_d2   <= '0;
            r_s1_cls  <= c_cls_bg;
            r_s1_code <= '0;
            r_rgb     <= '0;
        end else begin
            r_vde_d1  <= vde_in;
            r_cd_d1   <= cd_in;
            r_vde_d2  <= r_vde_d1;
            r_cd_d2   <= r_cd_d1;
            r_s1_cls  <= w_cls;
            r_s1_code <= w_code;
            if (!r_vde_d1) begin
                r_rgb <= '0;
            end else begin
                case (r_s1_cls)
                    c_cls_grid:   r_rgb <= 24'h202020;
                    c_cls_cell:   r_rgb <= f_palette(r_s1_code);
                    c_cls_border: r_rgb <= 24'h808080;
                    default:      r_rgb <= 24'h000000;
                endcase
            end
        end
    end

    assign swap_ack = r_swap_ack;
    assign vde_out  = r_vde_d2;
    assign cd_out   = r_cd_d2;
    assign r_out    = r_rgb[23:16];
    assign g_out    = r_rgb[15:8];
    assign b_out    = r_rgb[7:0];

endmodule
`default_nettype wire

// File: tb/tb_tetris_pixel_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tetris_pixel_renderer
// Description : Self-checking bench for tetris_pixel_renderer. Drives a
//               reduced-size video raster, directed board writes and swaps,
//               then random writes/swaps, and compares every output cycle
//               against a pixel-level reference model of the playfield.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tetris_pixel_renderer;

    localparam int P_H  = 56;
    localparam int P_V  = 88;
    localparam int P_CL = 2;
    localparam int P_OX = 8;
    localparam int P_OY = 4;
    localparam int P_B  = 2;
    localparam int CS   = 1 << P_CL;
    localparam int BW   = 10 * CS;
    localparam int BH   = 20 * CS;

    logic       pixclk = 1'b0;
    logic       rst_n;
    logic       vde_in;
    logic [1:0] cd_in;
    logic       wr_en;
    logic [3:0] wr_col;
    logic [4:0] wr_row;
    logic [2:0] wr_color;
    logic       swap_req;
    logic       swap_ack;
    logic       vde_out;
    logic [1:0] cd_out;
    logic [7:0] r_out, g_out, b_out;

    always #5 pixclk = ~pixclk;

    tetris_pixel_renderer #(
        .H_ACTIVE (P_H),
        .V_ACTIVE (P_V),
        .CELL_LOG2(P_CL),
        .ORIGIN_X (P_OX),
        .ORIGIN_Y (P_OY),
        .BORDER   (P_B)
    ) dut (
        .pixclk  (pixclk),
        .rst_n   (rst_n),
        .vde_in  (vde_in),
        .cd_in   (cd_in),
        .wr_en   (wr_en),
        .wr_col  (wr_col),
        .wr_row  (wr_row),
        .wr_color(wr_color),
        .swap_req(swap_req),
        .swap_ack(swap_ack),
        .vde_out (vde_out),
        .cd_out  (cd_out),
        .r_out   (r_out),
        .g_out   (g_out),
        .b_out   (b_out)
    );

    // Reference model state
    logic [23:0] pal [0:7] = '{24'h000000, 24'h00FFFF, 24'hFFFF00, 24'h800080,
                               24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFF8000};
    logic [2:0]  m_front [20][10];
    logic [2:0]  m_back  [20][10];
    logic        m_pending;
    logic        m_vs_prev;

    // Expectations for the outputs two samples behind the current inputs
    logic        p_vde;
    logic [1:0]  p_cd;
    logic [23:0] p_rgb;
    int          p_px, p_py;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (pixel x=%0d y=%0d): observed %h expected %h", tag, p_px, p_py, obs, exp);
    endtask

    function automatic logic [23:0] exp_pixel(input int x, input int y);
        int bx, by;
        bx = x - P_OX;
        by = y - P_OY;
        if (bx >= 0 && bx < BW && by >= 0 && by < BH) begin
            if ((bx % CS) == CS - 1 || (by % CS) == CS - 1) return 24'h202020;
            return pal[m_front[by / CS][bx / CS]];
        end
        if (x >= P_OX - P_B && x < P_OX + BW + P_B && y >= P_OY - P_B && y < P_OY + BH + P_B)
            return 24'h808080;
        return 24'h000000;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) begin
                m_front[r][c] = 3'd0;
                m_back[r][c]  = 3'd0;
            end
        m_pending = 1'b0;
        m_vs_prev = 1'b0;
        p_vde = 1'b0;
        p_cd  = 2'b00;
        p_rgb = 24'h0;
        p_px  = 0;
        p_py  = 0;
    endtask

    task automatic chk_reset_state();
        chk("reset_vde_out", {23'b0, vde_out}, 24'h0);
        chk("reset_cd_out", {22'b0, cd_out}, 24'h0);
        chk("reset_swap_ack", {23'b0, swap_ack}, 24'h0);
        chk("reset_rgb", {r_out, g_out, b_out}, 24'h0);
    endtask

    // One pixel clock: apply inputs, advance the model, check outputs.
    task automatic tick(input logic v, input logic vs, input logic hs, input int px, input int py);
        logic [23:0] e_rgb;
        logic        e_copy;
        vde_in = v;
        cd_in  = {vs, hs};
        e_rgb  = v ? exp_pixel(px, py) : 24'h0;
        e_copy = vs && !m_vs_prev && m_pending;
        if (e_copy) begin
            m_front   = m_back;
            m_pending = 1'b0;
        end else if (swap_req) begin
            m_pending = 1'b1;
        end
        if (wr_en && wr_col < 4'd10 && wr_row < 5'd20) m_back[wr_row][wr_col] = wr_color;
        m_vs_prev = vs;
        @(posedge pixclk);
        #1;
        chk("vde_out", {23'b0, vde_out}, {23'b0, p_vde});
        chk("cd_out", {22'b0, cd_out}, {22'b0, p_cd});
        chk("rgb", {r_out, g_out, b_out}, p_rgb);
        chk("swap_ack", {23'b0, swap_ack}, {23'b0, e_copy});
        p_vde    = v;
        p_cd     = {vs, hs};
        p_rgb    = e_rgb;
        p_px     = px;
        p_py     = py;
        wr_en    = 1'b0;
        swap_req = 1'b0;
    endtask

    task automatic idle_write(input logic [3:0] c, input logic [4:0] r, input logic [2:0] k);
        wr_en    = 1'b1;
        wr_col   = c;
        wr_row   = r;
        wr_color = k;
        tick(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic idle_req();
        swap_req = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        vde_in   = 1'b0;
        cd_in    = 2'b00;
        wr_en    = 1'b0;
        swap_req = 1'b0;
        #1;
        chk_reset_state();
        repeat (3) @(posedge pixclk);
        #3 rst_n = 1'b1;
        model_reset();
    endtask

    // One frame: vsync pulse (optionally with a write / swap_req in the
    // vsync-rise cycle), then P_V lines of P_H pixels with random hblank.
    task automatic frame(input bit rnd, input bit vs_wr, input logic [3:0] vc,
                         input logic [4:0] vr, input logic [2:0] vk, input bit vs_req,
                         input int rst_line);
        int nb;
        tick(1'b0, 1'b0, 1'b0, 0, 0);
        tick(1'b0, 1'b0, 1'b0, 0, 0);
        if (vs_wr) begin
            wr_en    = 1'b1;
            wr_col   = vc;
            wr_row   = vr;
            wr_color = vk;
        end
        swap_req = vs_req;
        tick(1'b0, 1'b1, 1'b0, 0, 0);
        tick(1'b0, 1'b1, 1'b0, 0, 0);
        tick(1'b0, 1'b0, 1'b0, 0, 0);
        tick(1'b0, 1'b0, 1'b0, 0, 0);
        for (int ln = 0; ln < P_V; ln++) begin
            for (int px = 0; px < P_H; px++) begin
                if (ln == rst_line && px == P_H / 2) begin
                    mid_reset();
                    return;
                end
                if (rnd) begin
                    if ($urandom_range(0, 15) == 0) begin
                        wr_en    = 1'b1;
                        wr_col   = 4'($urandom_range(0, 15));
                        wr_row   = 5'($urandom_range(0, 31));
                        wr_color = 3'($urandom_range(0, 7));
                    end
                    if ($urandom_range(0, 499) == 0) swap_req = 1'b1;
                end
                tick(1'b1, 1'b0, 1'b0, px, ln);
            end
            nb = $urandom_range(2, 4);
            for (int b = 0; b < nb; b++) tick(1'b0, 1'b0, (b == 1), 0, 0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        vde_in   = 1'b0;
        cd_in    = 2'b00;
        wr_en    = 1'b0;
        wr_col   = 4'd0;
        wr_row   = 5'd0;
        wr_color = 3'd0;
        swap_req = 1'b0;
        model_reset();
        #23;
        chk_reset_state();
        rst_n = 1'b1;

        // Empty board for two frames
        frame(1'b0, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);
        frame(1'b0, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);

        // Cell (0,0) red, published at the next vsync
        idle_write(4'd0, 5'd0, 3'd5);
        idle_req();
        frame(1'b0, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);

        // Cell (9,19) orange stays hidden without a swap
        idle_write(4'd9, 5'd19, 3'd7);
        frame(1'b0, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);
        frame(1'b0, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);
        frame(1'b0, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);

        // Out-of-range writes are dropped, then swap
        idle_write(4'd10, 5'd0, 3'd3);
        idle_write(4'd3, 5'd25, 3'd6);
        idle_write(4'd10, 5'd25, 3'd1);
        idle_write(4'd15, 5'd31, 3'd4);
        idle_req();
        frame(1'b0, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);

        // Write and swap_req in the copy cycle: write misses this copy,
        // request is absorbed so the next vsync does not swap
        idle_req();
        frame(1'b0, 1'b1, 4'd3, 5'd3, 3'd2, 1'b1, -1);
        frame(1'b0, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);
        idle_req();
        frame(1'b0, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);

        // Random writes and swaps, then a reset in the middle of a line
        frame(1'b1, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);
        frame(1'b1, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);
        frame(1'b1, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, 40);
        frame(1'b0, 1'b0, 4'd0, 5'd0, 3'd0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tetris_pixel_renderer.md
Name: tetris_pixel_renderer

Overview:
- Pixel source for the HDMI path. Sits between the video timing generator and the three TMDS encoders.
- Tracks the active-pixel position from VDE/CD and looks up the Tetris playfield cell under the beam. Emits 24-bit RGB, plus VDE/CD delayed to stay aligned with the RGB.
- Holds a double-buffered 10x20 board of 3-bit colour codes. Game logic writes the back buffer; the front buffer is updated only at frame start, so there is no tearing.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
CELL_LOG2, 4, log2 of cell size in pixels (16x16 cells)
ORIGIN_X, 240, x of board left edge
ORIGIN_Y, 80, y of board top edge
BORDER, 4, border thickness in pixels around the board

Ports:
pixclk  in  1  pixel clock, sole clock
rst_n  in  1  asynchronous active-low reset
vde_in  in  1  video data enable from timing generator
cd_in  in  2  control data from timing generator, {vsync, hsync}
wr_en  in  1  back-buffer write strobe
wr_col  in  4  write column, 0..9
wr_row  in  5  write row, 0..19, 0 = top
wr_color  in  3  colour code to write
swap_req  in  1  level request to publish the back buffer
swap_ack  out  1  one-cycle pulse when the copy is done
vde_out  out  1  vde_in delayed by 2
cd_out  out  2  cd_in delayed by 2
r_out  out  8  red
g_out  out  8  green
b_out  out  8  blue

Behaviour:
- Reset (async assert, sync release): x=0, y=0, both buffers all 0, swap_pending=0, swap_ack=0, vde_out=0, cd_out=0, RGB=0.
- Position counters:
  - x increments on each cycle with vde_in=1 and clears on the cycle after vde_in falls.
  - y increments when vde_in falls (1->0) and clears on the vsync (cd_in[1]) rising edge.
  - x saturates at H_ACTIVE-1; y saturates at V_ACTIVE-1.
- Board geometry: board spans x in [ORIGIN_X, ORIGIN_X+160) and y in [ORIGIN_Y, ORIGIN_Y+320).
  - col = (x-ORIGIN_X)>>CELL_LOG2; row = (y-ORIGIN_Y)>>CELL_LOG2.
  - No dividers. Subtraction is unsigned, guarded by the in-range compare.
- Pixel classification (priority order):
  - inside board, low CELL_LOG2 bits of (x-ORIGIN_X) or (y-ORIGIN_Y) all 1 -> grid 202020.
  - inside board otherwise -> palette[front[row][col]].
  - within BORDER px outside the board edge (rectangular ring) -> border 808080.
  - else -> background 000000.
  - vde=0 -> RGB 000000.
- Palette: 0=000000, 1=00FFFF, 2=FFFF00, 3=800080, 4=00FF00, 5=FF0000, 6=0000FF, 7=FF8000.
- Pipeline, latency 2 cycles from vde_in/cd_in to outputs:
  - Stage 1 registers classification and cell code.
  - Stage 2 registers RGB.
  - vde/cd pass through a matching 2-deep shift register.
- Writes: on wr_en with wr_col<10 and wr_row<20, back[wr_row][wr_col] <= wr_color next cycle. Out-of-range writes are ignored.
- Swap:
  - swap_req=1 sets swap_pending (idempotent while already pending).
  - On the vsync rising edge with swap_pending=1, the whole back buffer is copied into front in one cycle, swap_pending clears, and swap_ack pulses 1 cycle.
  - The game must drop swap_req on swap_ack. If swap_req is still high the cycle after the ack, it re-arms.
- Simultaneous events:
  - A write in the copy cycle lands in back but is not included in that copy.
  - swap_req arriving in the copy cycle is absorbed into the current swap (no re-arm).
- Mid-frame reset: everything returns to reset state. Output is black until the next valid VDE; board contents are lost.

Test Plan:
- Reset then 2 frames, no writes -> board pixels 000000, grid pixels 202020; (x=236,y=200) = 808080; (x=10,y=10) = 000000.
- Write col0,row0 = 5; swap_req; run to vsync -> swap_ack one pulse; next frame (x=240,y=80) = FF0000 and (x=255,y=80) = 202020.
- Write col9,row19 = 7 with no swap_req -> (x=398,y=398) stays 000000 through 3 frames; after swap it becomes FF8000.
- Write wr_col=10 and wr_row=25, then swap -> the entire front buffer is unchanged.
- Write col3,row3 = 2 in the same cycle as the vsync copy -> not visible in the following frame; visible after the next swap.
- Latency check: vde_in rise at cycle N -> vde_out rises at N+2; cd_out equals cd_in delayed by 2 throughout; assert rst_n low mid-line -> all outputs 0 immediately.
